instr_fetch: RTL



---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 45 ++++
 rtl/fetch_buf.sv | 57 +++++
 rtl/instr_fetch.sv | 88 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 8-bit lab CPU front end.
// Holds fetch state encodings, bus widths and the opcode field position.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DONE  = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_HI-OPC_LO:0] opcode(
    input logic [INSTR_W-1:0] instr
  );
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bundle: control (start/redirect/status), ROM port and decode handshake.
// master = fetch unit side, slave = CPU/ROM/decode side.
interface instr_fetch_if;

  logic                          start;
  logic [cpu_pkg::ADDR_W-1:0]    imem_addr;
  logic [cpu_pkg::INSTR_W-1:0]   imem_instr;
  logic [cpu_pkg::INSTR_W-1:0]   instr_out;
  logic [cpu_pkg::ADDR_W-1:0]    pc_out;
  logic                          instr_valid;
  logic                          instr_ready;
  logic                          redirect_valid;
  logic [cpu_pkg::ADDR_W-1:0]    redirect_pc;
  logic                          busy;
  logic                          done;

  modport master (
    input  start,
    input  imem_instr,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc,
    output imem_addr,
    output instr_out,
    output pc_out,
    output instr_valid,
    output busy,
    output done
  );

  modport slave (
    output start,
    output imem_instr,
    output instr_ready,
    output redirect_valid,
    output redirect_pc,
    input  imem_addr,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/fetch_buf.sv
// One-entry output register toward decode: load, hold while stalled, flush.
// Ports: clk_i/rst_i, load_i/flush_i/ready_i, instr_i/pc_i in, instr_o/pc_o/valid_o/slot_free_o out.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o,
  output logic               slot_free_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  assign slot_free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (ready_i) begin
      // Consumed with nothing new behind it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: owns the pc and IDLE/FETCH/DONE FSM, reads the ROM, feeds decode.
// Ports: clk, reset (async, active-high), bus (instr_fetch_if.master).
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned PROG_LEN   = 11,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_if.master     bus
);

  localparam logic [ADDR_W-1:0] LEN_A   = ADDR_W'(PROG_LEN);
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, done_q;
  logic              load, flush, slot_free;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect beats start and drops whatever decode has not taken.
      state_d = FS_FETCH;
      pc_d    = bus.redirect_pc;
      flush   = 1'b1;
    end else begin
      case (state_q)
        FS_IDLE, FS_DONE: begin
          if (bus.start) begin
            state_d = FS_FETCH;
            pc_d    = START_A;
          end
        end
        FS_FETCH: begin
          if (slot_free) begin
            if (pc_q < LEN_A) begin
              load = 1'b1;
              pc_d = pc_q + 8'd1;
            end else begin
              flush   = 1'b1;
              state_d = FS_DONE;
            end
          end
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d == FS_FETCH);
      done_q  <= (state_d == FS_DONE);
    end
  end

  fetch_buf u_buf (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (load),
    .flush_i     (flush),
    .ready_i     (bus.instr_ready),
    .instr_i     (bus.imem_instr),
    .pc_i        (pc_q),
    .instr_o     (bus.instr_out),
    .pc_o        (bus.pc_out),
    .valid_o     (bus.instr_valid),
    .slot_free_o (slot_free)
  );

  assign bus.imem_addr = pc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
